// File: rtl/usb_rcu_pkg.sv
// USB receiver control unit: shared state encodings and constants.
// Imported by the RCU top, its bit counter and the bench.
package usb_rcu_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'h80;

  typedef logic [3:0] rcu_state_t;

  localparam rcu_state_t ST_IDLE       = 4'd0;
  localparam rcu_state_t ST_SYNC_WAIT  = 4'd1;
  localparam rcu_state_t ST_SYNC_CHECK = 4'd2;
  localparam rcu_state_t ST_RECV       = 4'd3;
  localparam rcu_state_t ST_STORE      = 4'd4;
  localparam rcu_state_t ST_EOP_WAIT   = 4'd5;
  localparam rcu_state_t ST_ERR        = 4'd6;
  localparam rcu_state_t ST_ERR_EOP    = 4'd7;
  localparam rcu_state_t ST_ERR_IDLE   = 4'd8;

endpackage

// File: rtl/usb_rcu_if.sv
// Bus between the USB line front end (shifter/edge detector)
// and the receive control unit.
interface usb_rcu_if;
  logic       d_edge;
  logic       eop;
  logic       shift_enable;
  logic       byte_received;
  logic [7:0] rcv_data;
  logic       rcving;
  logic       w_enable;
  logic       r_error;

  modport master (
    output d_edge,
    output eop,
    output shift_enable,
    output byte_received,
    output rcv_data,
    input  rcving,
    input  w_enable,
    input  r_error
  );

  modport slave (
    input  d_edge,
    input  eop,
    input  shift_enable,
    input  byte_received,
    input  rcv_data,
    output rcving,
    output w_enable,
    output r_error
  );
endinterface

// File: rtl/rcu_bit_cnt.sv
// 3-bit bit-position counter for the RCU.
// Synchronous clear takes priority over count.
module rcu_bit_cnt (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       i_count_enable,
  input  logic       i_clear,
  output logic [2:0] o_count
);

  logic [2:0] r_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count_enable) begin
      r_count <= r_count + 3'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/usb_rcu.sv
// USB receive control unit: sync check, byte store strobes,
// end-of-packet alignment check and sticky error.
module usb_rcu
  import usb_rcu_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
  input logic      clk,
  input logic      n_rst,
  usb_rcu_if.slave bus
);

  rcu_state_t r_state;
  rcu_state_t w_next;
  logic       r_rcving;
  logic       r_wen;
  logic       r_err;
  logic       w_eop_se;
  logic       w_cnt_en;
  logic       w_cnt_clr;
  logic       w_err_clr;
  logic [2:0] w_cnt;

  assign w_eop_se = bus.eop && bus.shift_enable;

  // Counter only tracks bit position inside data bytes
  assign w_cnt_en  = (r_state == ST_RECV) && bus.shift_enable;
  assign w_cnt_clr = bus.byte_received || (r_state != ST_RECV);

  rcu_bit_cnt u_bit_cnt (
    .clk            (clk),
    .n_rst          (n_rst),
    .i_count_enable (w_cnt_en),
    .i_clear        (w_cnt_clr),
    .o_count        (w_cnt)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.d_edge) w_next = ST_SYNC_WAIT;
      end
      ST_SYNC_WAIT: begin
        if (bus.byte_received) w_next = ST_SYNC_CHECK;
        else if (w_eop_se)     w_next = ST_ERR;
      end
      ST_SYNC_CHECK: begin
        if (bus.rcv_data == SYNC_BYTE) w_next = ST_RECV;
        else                           w_next = ST_ERR;
      end
      ST_RECV: begin
        if (bus.byte_received) w_next = ST_STORE;
        else if (w_eop_se)
          w_next = (w_cnt == 3'd0) ? ST_EOP_WAIT : ST_ERR;
      end
      ST_STORE: begin
        w_next = ST_RECV;
      end
      ST_EOP_WAIT: begin
        if (bus.d_edge) w_next = ST_IDLE;
      end
      ST_ERR: begin
        w_next = ST_ERR_EOP;
      end
      ST_ERR_EOP: begin
        if (w_eop_se) w_next = ST_ERR_IDLE;
      end
      ST_ERR_IDLE: begin
        if (bus.d_edge) w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Error is only cleared when a new packet starts
  assign w_err_clr = (r_state == ST_IDLE) && bus.d_edge;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= ST_IDLE;
      r_rcving <= 1'b0;
      r_wen    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_rcving <= (w_next != ST_IDLE) && (w_next != ST_ERR_IDLE);
      r_wen    <= (w_next == ST_STORE);
      if (w_err_clr)              r_err <= 1'b0;
      else if (w_next == ST_ERR)  r_err <= 1'b1;
    end
  end

  assign bus.rcving   = r_rcving;
  assign bus.w_enable = r_wen;
  assign bus.r_error  = r_err;

endmodule
